// File: rtl/proc_imul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among several pipeline requesters.
// One transaction may be in flight; its product is steered back to the recorded owner only.
module proc_imul_arbiter #(
   parameter int unsigned p_num_reqs   = 4,
   parameter int unsigned p_req_nbits  = 64,
   parameter int unsigned p_resp_nbits = 32,
   localparam int unsigned c_id_nbits  = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [p_num_reqs-1:0]            req_val,
   output logic [p_num_reqs-1:0]            req_rdy,
   input  logic [p_num_reqs*p_req_nbits-1:0] req_msg,
   output logic [p_num_reqs-1:0]            resp_val,
   input  logic [p_num_reqs-1:0]            resp_rdy,
   output logic [p_resp_nbits-1:0]          resp_msg,
   output logic                             mul_req_val,
   input  logic                             mul_req_rdy,
   output logic [p_req_nbits-1:0]           mul_req_msg,
   input  logic                             mul_resp_val,
   output logic                             mul_resp_rdy,
   input  logic [p_resp_nbits-1:0]          mul_resp_msg,
   output logic                             busy,
   output logic [c_id_nbits-1:0]            owner_id
);

   typedef enum logic {StIdle, StWait} state_e;

   localparam logic [c_id_nbits:0]   c_num  = (c_id_nbits + 1)'(p_num_reqs);
   localparam logic [c_id_nbits-1:0] c_last = c_id_nbits'(p_num_reqs - 1);

   state_e                  state_q, state_d;
   logic [c_id_nbits-1:0]   owner_q, owner_d;
   logic [c_id_nbits-1:0]   prio_q, prio_d;

   logic [c_id_nbits-1:0]   grant;
   logic                    grant_found;
   logic [p_num_reqs-1:0]   grant_oh;
   logic [p_num_reqs-1:0]   owner_oh;
   logic [p_req_nbits-1:0]  sel_msg;
   logic                    owner_rdy;
   logic [c_id_nbits-1:0]   next_prio;

   // Rotating priority search starting at prio_q, wrapping modulo p_num_reqs.
   always_comb begin
      logic [c_id_nbits:0]   sum;
      logic [c_id_nbits-1:0] idx;
      grant       = '0;
      grant_found = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < int'(p_num_reqs); k++) begin
         sum = {1'b0, prio_q} + (c_id_nbits + 1)'(k);
         if (sum >= c_num) begin
            sum = sum - c_num;
         end
         idx = c_id_nbits'(sum);
         if (!grant_found && req_val[idx]) begin
            grant_found = 1'b1;
            grant       = idx;
         end
      end
   end

   always_comb begin
      grant_oh  = '0;
      owner_oh  = '0;
      sel_msg   = '0;
      owner_rdy = 1'b0;
      for (int i = 0; i < int'(p_num_reqs); i++) begin
         grant_oh[i] = grant_found && (grant == c_id_nbits'(i));
         owner_oh[i] = (owner_q == c_id_nbits'(i));
         if (grant_oh[i]) begin
            sel_msg = req_msg[i*p_req_nbits +: p_req_nbits];
         end
         if (owner_oh[i]) begin
            owner_rdy = resp_rdy[i];
         end
      end
   end

   assign next_prio = (grant == c_last) ? '0 : grant + 1'b1;

   // Outputs are forced low while reset is held, independent of the requesters.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      prio_d       = prio_q;
      req_rdy      = '0;
      resp_val     = '0;
      mul_req_val  = 1'b0;
      mul_resp_rdy = 1'b0;
      busy         = 1'b0;
      mul_req_msg  = sel_msg;
      resp_msg     = mul_resp_msg;
      if (reset) begin
         case (state_q)
            StIdle: begin
               mul_req_val = grant_found;
               req_rdy     = grant_oh & {p_num_reqs{mul_req_rdy}};
               if (grant_found && mul_req_rdy) begin
                  owner_d = grant;
                  prio_d  = next_prio;
                  state_d = StWait;
               end
            end
            StWait: begin
               busy         = 1'b1;
               resp_val     = owner_oh & {p_num_reqs{mul_resp_val}};
               mul_resp_rdy = owner_rdy;
               if (mul_resp_val && owner_rdy) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         owner_q <= '0;
         prio_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
      end
   end

   assign owner_id = owner_q;

endmodule

// File: tb/tb_proc_imul_arbiter.sv
// Bench for proc_imul_arbiter: 4-cycle multiplier model, scoreboard on response handshakes,
// a table of single-requester transactions and directed multi-cycle sequences.
module tb_proc_imul_arbiter;

   localparam int N   = 4;
   localparam int RQW = 64;
   localparam int RSW = 32;
   localparam int LAT = 4;

   logic             clk;
   logic             reset;
   logic [N-1:0]     req_val;
   logic [N-1:0]     req_rdy;
   logic [N*RQW-1:0] req_msg;
   logic [N-1:0]     resp_val;
   logic [N-1:0]     resp_rdy;
   logic [RSW-1:0]   resp_msg;
   logic             mul_req_val;
   logic             mul_req_rdy;
   logic [RQW-1:0]   mul_req_msg;
   logic             mul_resp_val;
   logic             mul_resp_rdy;
   logic [RSW-1:0]   mul_resp_msg;
   logic             busy;
   logic [1:0]       owner_id;

   proc_imul_arbiter #(
      .p_num_reqs  (N),
      .p_req_nbits (RQW),
      .p_resp_nbits(RSW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_msg     (req_msg),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_msg    (resp_msg),
      .mul_req_val (mul_req_val),
      .mul_req_rdy (mul_req_rdy),
      .mul_req_msg (mul_req_msg),
      .mul_resp_val(mul_resp_val),
      .mul_resp_rdy(mul_resp_rdy),
      .mul_resp_msg(mul_resp_msg),
      .busy        (busy),
      .owner_id    (owner_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Iterative multiplier model sharing the arbiter reset
   logic           m_busy, m_val;
   int             m_cnt;
   logic [RSW-1:0] m_prod;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_val  <= 1'b0;
         m_cnt  <= 0;
         m_prod <= '0;
      end else if (!m_busy && mul_req_val) begin
         m_busy <= 1'b1;
         m_cnt  <= LAT - 1;
         m_prod <= mul_req_msg[63:32] * mul_req_msg[31:0];
      end else if (m_busy && !m_val) begin
         if (m_cnt == 0) m_val <= 1'b1;
         else m_cnt <= m_cnt - 1;
      end else if (m_val && mul_resp_rdy) begin
         m_val  <= 1'b0;
         m_busy <= 1'b0;
      end
   end

   assign mul_req_rdy  = !m_busy;
   assign mul_resp_val = m_val;
   assign mul_resp_msg = m_prod;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int             id;
      logic [RSW-1:0] prod;
   } sb_t;

   sb_t sb[$];
   int  glog[$];

   // Scoreboard: expectation pushed on request handshake, compared on response handshake
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            if (req_val[i] && req_rdy[i]) begin
               logic [RQW-1:0] m;
               sb_t e;
               m      = req_msg[i*RQW +: RQW];
               e.id   = i;
               e.prod = m[63:32] * m[31:0];
               sb.push_back(e);
               glog.push_back(i);
            end
            if (resp_val[i] && resp_rdy[i]) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 64'd1, 64'd0);
               end else begin
                  sb_t e;
                  e = sb.pop_front();
                  check("sb_owner", 64'(i), 64'(e.id));
                  check("sb_product", 64'(resp_msg), 64'(e.prod));
               end
            end
         end
      end
   end

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
      req_msg[id*RQW +: RQW] = {a, b};
   endtask

   task automatic apply_reset(input int ncyc, input logic [N-1:0] rv);
      req_val = rv;
      reset   = 1'b0;
      sb.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check("reset_outputs", 64'({req_rdy, resp_val, mul_req_val, mul_resp_rdy, busy}), 64'd0);
      end
      @(posedge clk);
      #1;
      req_val = '0;
      reset   = 1'b1;
      @(negedge clk);
      check("release_owner", 64'(owner_id), 64'd0);
      check("release_outputs", 64'({req_rdy, resp_val, mul_req_val, mul_resp_rdy, busy}), 64'd0);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      while ((busy || sb.size() != 0) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check(name, 64'({busy, 1'(sb.size() != 0)}), 64'd0);
   endtask

   task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int t;
      bit busy_ok;
      set_req(id, a, b);
      req_val = '0;
      req_val[id] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_rdy[id] && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (!req_rdy[id]) begin
         check("grant_timeout", 64'd0, 64'd1);
         req_val = '0;
         return;
      end
      check("mul_req_msg", mul_req_msg, {a, b});
      check("busy_at_grant", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      req_val = '0;
      busy_ok = 1'b1;
      t = 0;
      @(negedge clk);
      while (resp_val == '0 && t < 30) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         t++;
      end
      if (!busy) busy_ok = 1'b0;
      check("busy_window", 64'(busy_ok), 64'd1);
      check("resp_val", 64'(resp_val), 64'(4'd1 << id));
      check("resp_msg", 64'(resp_msg), 64'(exp));
      check("owner_id", 64'(owner_id), 64'(id));
      @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
   endtask

   // Collect grants, retiring each granted requester so it is not granted again
   task automatic collect_grants(input int want);
      int t;
      t = 0;
      while (glog.size() < want && t < 300) begin
         @(posedge clk);
         #1;
         foreach (glog[k]) req_val[glog[k]] = 1'b0;
         t++;
      end
      req_val = '0;
      check("grant_count", 64'(glog.size()), 64'(want));
   endtask

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int t;
      bit ok;
      int rr_exp[6];
      vecs[0] = '{id: 2, a: 32'd7,          b: 32'd6,       p: 32'd42};
      vecs[1] = '{id: 0, a: 32'hFFFF_FFFF,  b: 32'd2,       p: 32'hFFFF_FFFE};
      vecs[2] = '{id: 3, a: 32'd1000,       b: 32'd1000,    p: 32'd1000000};
      vecs[3] = '{id: 1, a: 32'd0,          b: 32'd123,     p: 32'd0};
      vecs[4] = '{id: 1, a: 32'h0001_0000,  b: 32'h0001_0000, p: 32'd0};
      rr_exp  = '{0, 1, 2, 3, 0, 1};

      reset    = 1'b0;
      req_val  = '0;
      req_msg  = '0;
      resp_rdy = '1;

      // Reset with all requesters asserting
      apply_reset(3, '1);

      foreach (vecs[v]) run_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].p);
      wait_idle("table_drain");

      // Round-robin from prio_ptr=0 with every requester continuously valid
      apply_reset(1, '0);
      glog.delete();
      for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(i + 11));
      req_val = '1;
      t = 0;
      while (glog.size() < 6 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      req_val = '0;
      check("rr_count", 64'(glog.size()), 64'd6);
      for (int k = 0; k < 6 && k < glog.size(); k++) check("rr_order", 64'(glog[k]), 64'(rr_exp[k]));
      wait_idle("rr_drain");

      // Wrap and skip: grant 2 leaves prio_ptr=3, then only req 1, then 3 and 0 together
      run_one(2, 32'd3, 32'd5, 32'd15);
      glog.delete();
      run_one(1, 32'd9, 32'd9, 32'd81);
      check("skip_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);
      glog.delete();
      set_req(3, 32'd2, 32'd21);
      set_req(0, 32'd4, 32'd25);
      req_val = 4'b1001;
      collect_grants(2);
      if (glog.size() == 2) begin
         check("wrap_first", 64'(glog[0]), 64'd3);
         check("wrap_second", 64'(glog[1]), 64'd0);
      end
      wait_idle("wrap_drain");

      // Response back-pressure from owner 1 with req 0 waiting
      glog.delete();
      resp_rdy = 4'b1101;
      set_req(1, 32'd12, 32'd12);
      set_req(0, 32'd5, 32'd5);
      req_val = 4'b0010;
      t = 0;
      @(negedge clk);
      while (!req_rdy[1] && t < 30) begin
         @(negedge clk);
         t++;
      end
      check("bp_grant", 64'(req_rdy[1]), 64'd1);
      @(posedge clk);
      #1;
      req_val = 4'b0001;
      ok = 1'b1;
      t = 0;
      @(negedge clk);
      while (!resp_val[1] && t < 30) begin
         if (mul_resp_rdy || req_rdy[0]) ok = 1'b0;
         @(negedge clk);
         t++;
      end
      for (int c = 0; c < 5; c++) begin
         if (mul_resp_rdy || req_rdy[0] || resp_val != 4'b0010) ok = 1'b0;
         @(negedge clk);
      end
      check("bp_hold", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      resp_rdy = '1;
      @(negedge clk);
      check("bp_release_hs", 64'({resp_val, mul_resp_rdy, req_rdy[0]}), 64'b0010_1_0);
      @(negedge clk);
      check("bp_next_accept", 64'({req_rdy[0], busy}), 64'b1_0);
      @(posedge clk);
      #1;
      req_val = '0;
      wait_idle("bp_drain");

      // Reset while an operation from req 2 is in flight
      set_req(2, 32'd8, 32'd8);
      req_val = 4'b0100;
      t = 0;
      @(negedge clk);
      while (!req_rdy[2] && t < 30) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      req_val = '0;
      @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      #1;
      check("mid_reset_now", 64'({busy, resp_val, mul_resp_rdy, mul_req_val}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_owner", 64'(owner_id), 64'd0);
      ok = 1'b1;
      for (int c = 0; c < LAT + 3; c++) begin
         if (resp_val != '0 || busy) ok = 1'b0;
         @(negedge clk);
      end
      check("mid_no_resp", 64'(ok), 64'd1);
      glog.delete();
      set_req(3, 32'd6, 32'd7);
      set_req(0, 32'd10, 32'd11);
      req_val = 4'b1001;
      collect_grants(2);
      if (glog.size() == 2) begin
         check("mid_first", 64'(glog[0]), 64'd0);
         check("mid_second", 64'(glog[1]), 64'd3);
      end
      wait_idle("mid_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_imul_arbiter.md
Name: proc_imul_arbiter

Overview:
- Shares one iterative integer multiplier (64b request {op1,op2}, 32b product, val/rdy on both sides) among p_num_reqs pipeline requesters, such as the D/X stages of several cores in a multicore build.
- Arbitrates round-robin and allows one outstanding transaction.
- Records the owner of the in-flight operation and steers the product back to that owner only.
- Sits between the per-core datapath multiply ports and the single shared multiplier instance.

Parameters:
- p_num_reqs, 4, number of requesters; legal range 1..16.
- p_req_nbits, 64, request message width ({op1, op2}).
- p_resp_nbits, 32, response message width.
- c_id_nbits, localparam, $clog2(p_num_reqs) with a minimum of 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_val  in  p_num_reqs  per-requester request valid.
- req_rdy  out  p_num_reqs  per-requester request ready.
- req_msg  in  p_num_reqs*p_req_nbits  packed requests; requester i occupies bits [i*p_req_nbits +: p_req_nbits].
- resp_val  out  p_num_reqs  per-requester response valid.
- resp_rdy  in  p_num_reqs  per-requester response ready.
- resp_msg  out  p_resp_nbits  product, broadcast to all requesters; qualified only by resp_val.
- mul_req_val  out  1  request valid to the multiplier.
- mul_req_rdy  in  1  multiplier request ready.
- mul_req_msg  out  p_req_nbits  selected request.
- mul_resp_val  in  1  multiplier response valid.
- mul_resp_rdy  out  1  ready to the multiplier.
- mul_resp_msg  in  p_resp_nbits  multiplier product.
- busy  out  1  high while a transaction is outstanding.
- owner_id  out  c_id_nbits  index of the current or last granted requester.

Behaviour:
- State machine has two states, IDLE and WAIT. Registered state: state, owner_id, prio_ptr (c_id_nbits).
- Reset (asynchronous, on reset==0):
  - state=IDLE, owner_id=0, prio_ptr=0.
  - All outputs read 0: req_rdy, resp_val, mul_req_val, mul_resp_rdy, busy.
  - resp_msg and mul_req_msg are don't-care.
  - Reset mid-transaction discards the in-flight op; the multiplier shares the same reset.
- Grant logic (combinational, evaluated in IDLE only):
  - grant = first i with req_val[i]=1, searching prio_ptr, prio_ptr+1, ... and wrapping modulo p_num_reqs.
  - Selection is one-hot; no grant when req_val is all zero.
- IDLE outputs:
  - mul_req_val = |req_val.
  - mul_req_msg = req_msg slice of grant.
  - req_rdy[grant] = mul_req_rdy; all other req_rdy bits = 0.
  - mul_resp_rdy = 0; resp_val = 0; busy = 0.
- IDLE transition: on mul_req_val && mul_req_rdy → owner_id ← grant, prio_ptr ← (grant+1) mod p_num_reqs, state ← WAIT.
- WAIT outputs:
  - mul_req_val = 0; req_rdy = 0; busy = 1.
  - resp_val[owner_id] = mul_resp_val; all other resp_val bits = 0.
  - mul_resp_rdy = resp_rdy[owner_id].
  - resp_msg = mul_resp_msg.
- WAIT transition: on mul_resp_val && resp_rdy[owner_id] → state ← IDLE. A new request is accepted at the earliest in the following cycle; request and response are never handshaked in the same cycle.
- Latency: zero added cycles on both paths, since request and response pass through combinationally. Issue-to-issue spacing is multiplier latency + 1 cycle minimum.
- Back-pressure: a stalled owner holds the multiplier response indefinitely, and other requesters wait; this is intended.
- Stray mul_resp_val in IDLE is ignored (mul_resp_rdy=0).
- resp_val/resp_rdy of non-owners have no effect.
- Request stability: a requester changing req_val or req_msg before its handshake is legal. Arbitration re-evaluates every cycle, and prio_ptr updates only on a handshake.
- Wrap-around: prio_ptr = p_num_reqs-1 followed by a grant to the same requester gives prio_ptr=0.
- p_num_reqs=1 degenerates to a pass-through with an IDLE/WAIT interlock; owner_id stays 0.
- No combinational path from mul_resp_val to req_rdy; the state register separates the two.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset=0 for 3 cycles with all req_val=1; then release reset with all req_val=0.
  - Required: all val/rdy outputs 0 and busy=0 throughout; owner_id=0 after release.
- Single request:
  - Stimulus: req 2 with msg {op1=7, op2=6}; multiplier has 4-cycle latency and returns 42.
  - Required: mul_req_msg = {7,6}; resp_val=4'b0100 with resp_msg=42; busy high exactly from the grant-cycle+1 to the resp handshake; owner_id=2.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, responses always accepted.
  - Required: grant order 0,1,2,3,0,1; each done exactly once per 4 ops.
- Wrap and skip:
  - Stimulus: prio_ptr=3 with only req 1 valid.
  - Required: grant to 1, prio_ptr becomes 2; then req 3 and req 0 valid → grant 3, then 0.
- Response back-pressure:
  - Stimulus: owner 1 holds resp_rdy=0 for 5 cycles while req 0 is valid.
  - Required: mul_resp_rdy=0 and req_rdy[0]=0 throughout; resp handshake occurs in the cycle resp_rdy[1] rises; req 0 is accepted the next cycle.
- Mid-transaction reset:
  - Stimulus: assert reset while in WAIT, then send a new request from req 3.
  - Required: immediately IDLE, busy=0, no resp_val pulse; the req 3 grant proceeds from prio_ptr=0.
